// File: rtl/mmio_bus_arbiter.sv
// Two-master arbiter for the shared memory-mapped data bus.
// Each access is sequenced as grant, bus phase held until the slave is ready
// (or the wait counter expires), then a one-cycle completion pulse to the owner.
module mmio_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERROR_DATA     = 32'hDEADBEEF
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  // master 0 (CPU core)
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_done,
  output logic        m0_err,
  // master 1 (DMA / debug)
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_done,
  output logic        m1_err,
  // slave-side bus
  output logic [31:0] DAddress,
  output logic [31:0] DWriteData,
  output logic [3:0]  DByteEnable,
  output logic        DReadEnable,
  output logic        DWriteEnable,
  input  logic [31:0] DReadData,
  input  logic        DReady,
  // status
  output logic        grant_owner,
  output logic        busy
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             owner_d;
  logic [31:0]      addr_d, wdata_d;
  logic [3:0]       be_d;
  logic             rd_en_d, wr_en_d;
  logic [31:0]      m0_rdata_d, m1_rdata_d;
  logic             m0_done_d, m1_done_d, m0_err_d, m1_err_d;
  logic             busy_d;
  logic             sel;
  logic             finish;
  logic             timed_out;
  logic [31:0]      cap_data;

  // Next-state and next-register values; every register holds unless a transition updates it.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    owner_d      = grant_owner;
    addr_d       = DAddress;
    wdata_d      = DWriteData;
    be_d         = DByteEnable;
    rd_en_d      = DReadEnable;
    wr_en_d      = DWriteEnable;
    m0_rdata_d   = m0_rdata;
    m1_rdata_d   = m1_rdata;
    m0_done_d    = 1'b0;
    m1_done_d    = 1'b0;
    m0_err_d     = 1'b0;
    m1_err_d     = 1'b0;
    busy_d       = busy;
    sel          = 1'b0;
    finish       = 1'b0;
    timed_out    = 1'b0;
    cap_data     = DReadData;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // Round-robin on a tie: the master that did not win last time goes first.
          sel     = (m0_req && m1_req) ? ~last_grant_q : m1_req;
          owner_d = sel;
          addr_d  = sel ? m1_addr  : m0_addr;
          wdata_d = sel ? m1_wdata : m0_wdata;
          be_d    = sel ? m1_be    : m0_be;
          we_d    = sel ? m1_we    : m0_we;
          rd_en_d = sel ? ~m1_we   : ~m0_we;
          wr_en_d = sel ? m1_we    : m0_we;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Slave ready takes priority over an expiring wait counter.
        if (DReady) begin
          finish    = 1'b1;
          timed_out = 1'b0;
          cap_data  = DReadData;
        end else if (cnt_q == CNT_LAST) begin
          finish    = 1'b1;
          timed_out = 1'b1;
          cap_data  = ERROR_DATA;
        end
        if (finish) begin
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
          state_d = RESP;
          if (grant_owner) begin
            m1_done_d = 1'b1;
            m1_err_d  = timed_out;
            if (!we_q) m1_rdata_d = cap_data;
          end else begin
            m0_done_d = 1'b1;
            m0_err_d  = timed_out;
            if (!we_q) m0_rdata_d = cap_data;
          end
        end
      end

      RESP: begin
        // Requests are not looked at here, so the owner's falling req cannot re-grant.
        last_grant_d = grant_owner;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end

      default: begin
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      grant_owner  <= 1'b0;
      DAddress     <= '0;
      DWriteData   <= '0;
      DByteEnable  <= '0;
      DReadEnable  <= 1'b0;
      DWriteEnable <= 1'b0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
      m0_done      <= 1'b0;
      m1_done      <= 1'b0;
      m0_err       <= 1'b0;
      m1_err       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      grant_owner  <= owner_d;
      DAddress     <= addr_d;
      DWriteData   <= wdata_d;
      DByteEnable  <= be_d;
      DReadEnable  <= rd_en_d;
      DWriteEnable <= wr_en_d;
      m0_rdata     <= m0_rdata_d;
      m1_rdata     <= m1_rdata_d;
      m0_done      <= m0_done_d;
      m1_done      <= m1_done_d;
      m0_err       <= m0_err_d;
      m1_err       <= m1_err_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: doc/mmio_bus_arbiter.md
# mmio_bus_arbiter

Arbitrates the shared memory-mapped data bus between two masters, the CPU core (M0) and a secondary master (M1, DMA or debug), and drives the single slave-side bus that all peripheral interfaces decode. The arbiter sequences each access: grant, a bus phase held until the slave signals ready, then a one-cycle completion pulse. A timeout counter ends accesses to addresses that nobody decodes. The block sits between the masters and the DAddress/DReadData bus fabric in the top level.

## Interface
- TIMEOUT_CYCLES, 16: maximum number of bus-phase cycles before a forced error completion. Legal range is 2..255.
- ERROR_DATA, 32'hDEADBEEF: read data returned on a timed-out read.
- iCLK  in  1  core clock. All state changes on its rising edge.
- iRST_N  in  1  reset, asynchronous and active-low.
- m0_req, m1_req  in  1  access request. The master holds it, with stable fields, until its done pulse.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_be, m1_be  in  4  byte enables.
- m0_addr, m1_addr  in  32  address.
- m0_wdata, m1_wdata  in  32  write data.
- m0_rdata, m1_rdata  out  32  read data, held until the next read completion to that master.
- m0_done, m1_done  out  1  one-cycle completion pulse.
- m0_err, m1_err  out  1  timeout flag, valid only while the matching done is high.
- DAddress, DWriteData  out  32  slave-side address and write data.
- DByteEnable  out  4  slave-side byte enables.
- DReadEnable, DWriteEnable  out  1  slave-side strobes.
- DReadData  in  32  slave read data.
- DReady  in  1  slave ready. Sampled only in ACCESS.
- grant_owner  out  1  owner of the current or last transaction (0 = M0).
- busy  out  1  high in ACCESS and RESP.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - No request pending: stay in IDLE.
  - Exactly one request pending: grant that master.
  - Both requests pending: grant the master that was not last_grant (round-robin).
  - On grant: latch the owner's addr, we, be and wdata into the bus registers, clear the wait counter, go to ACCESS.
- **ACCESS**
  - DReadEnable = ~we and DWriteEnable = we. Both strobes are 0 in every other state.
  - The wait counter increments each cycle.
  - If DReady = 1: capture DReadData when the access is a read, set err = 0, go to RESP.
  - Else if the counter equals TIMEOUT_CYCLES-1: set err = 1, capture ERROR_DATA when the access is a read, go to RESP.
  - If DReady and the timeout occur in the same cycle, DReady wins and err = 0.
- **RESP**
  - Pulse done for the owner. Assert err for the owner if it was set.
  - Update m*_rdata for the owner on reads only.
  - Set last_grant to the owner and return to IDLE.
  - Requests seen in RESP are ignored. They are evaluated in IDLE on the next cycle, so the owner's deasserting req never causes a re-grant.
- Write accesses leave m*_rdata unchanged.
- The non-owner's done and err stay 0.
- DAddress, DWriteData and DByteEnable hold their last latched values outside ACCESS. Peripherals must qualify on the strobes only.
- Fairness: with both masters requesting continuously, grants alternate M0, M1, M0, …

## Timing
- Reset values:
  - state = IDLE, last_grant = 1 (so M0 wins the first tie), grant_owner = 0.
  - All D* outputs = 0.
  - m*_rdata = 0, m*_done = 0, m*_err = 0, busy = 0.
- Minimum transaction with DReady high in the first ACCESS cycle:
  - req sampled in IDLE at cycle 0.
  - Strobe high in cycle 1.
  - done high in cycle 2.
  - Back in IDLE in cycle 3.
- Back-to-back throughput is one access every 3 cycles.
- A timed-out access has exactly TIMEOUT_CYCLES cycles of strobe, followed by one done cycle.
- A reset assertion mid-transaction aborts it immediately and asynchronously: strobes drop and no done is issued.
- Outputs are registered. The only combinational path is DReadData into the capture register.

## Test plan
- Single read: M0 reads 0xFF200000 and the slave returns 0x12345678 with DReady in the first ACCESS cycle. Required: DReadEnable high for 1 cycle, m0_done in cycle 2, m0_rdata = 0x12345678, m0_err = 0.
- Write with wait states: M1 writes 0xA5A5A5A5 with be = 4'b0011, and DReady rises on the 4th ACCESS cycle. Required: DWriteEnable high for 4 cycles, DByteEnable = 0011, m1_done one cycle later, m1_rdata unchanged.
- Contention: both masters request continuously for 6 transactions from reset. Required: grant_owner sequence 0,1,0,1,0,1 and exactly one done per transaction.
- Timeout: M0 reads with DReady held at 0 and TIMEOUT_CYCLES = 16. Required: strobe high for 16 cycles, m0_done with m0_err = 1, m0_rdata = 0xDEADBEEF.
- Ready/timeout tie: DReady rises on cycle 16 of ACCESS. Required: m0_err = 0 and the slave data is captured.
- Reset mid-access: iRST_N pulled low during ACCESS. Required: strobes and busy go to 0 in the same cycle without a clock edge, no done pulse, and M0 wins the next tie after release.
